// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register with a load-use hazard detector,
//               external stall, branch flush and a saturating counter of
//               inserted bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              Stall_i,
    input  logic              Flush_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              Branch_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [DATA_W-1:0] PC_i,
    input  logic [9:0]        funct_i,
    input  logic [4:0]        RS1addr_i,
    input  logic [4:0]        RS2addr_i,
    input  logic [4:0]        RDaddr_i,
    output logic [1:0]        ALUOp_o,
    output logic              ALUSrc_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              Branch_o,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [DATA_W-1:0] PC_o,
    output logic [9:0]        funct_o,
    output logic [4:0]        RS1addr_o,
    output logic [4:0]        RS2addr_o,
    output logic [4:0]        RDaddr_o,
    output logic              Valid_o,
    output logic              NoOp_o,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o,
    output logic [CNT_W-1:0]  BubbleCnt_o
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    // Stage state: control bundle, operands and bookkeeping
    logic [1:0]        aluop_q,    aluop_d;
    logic              alusrc_q,   alusrc_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic              memread_q,  memread_d;
    logic              memwrite_q, memwrite_d;
    logic              branch_q,   branch_d;
    logic [DATA_W-1:0] rs1data_q,  rs1data_d;
    logic [DATA_W-1:0] rs2data_q,  rs2data_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [DATA_W-1:0] pc_q,       pc_d;
    logic [9:0]        funct_q,    funct_d;
    logic [4:0]        rs1addr_q,  rs1addr_d;
    logic [4:0]        rs2addr_q,  rs2addr_d;
    logic [4:0]        rdaddr_q,   rdaddr_d;
    logic              valid_q,    valid_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic              w_hazard;
    logic              w_bubble;

    // Load in EX whose destination (not x0) is read by the instruction in ID
    always_comb begin
        w_hazard = memread_q & valid_q & (rdaddr_q != 5'd0) &
                   ((rdaddr_q == RS1addr_i) | (rdaddr_q == RS2addr_i));
        w_bubble = Flush_i | w_hazard;
    end

    // Hazard-unit outputs; reset forces the front end to keep running
    always_comb begin
        NoOp_o      = 1'b0;
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
        if (!rst_i) begin
            NoOp_o      = w_hazard & ~Stall_i;
            PCWrite_o   = ~(w_hazard | Stall_i);
            IFIDWrite_o = ~(w_hazard | Stall_i);
        end
    end

    // Next-state selection: stall holds, flush/hazard bubbles, else load ID
    always_comb begin
        aluop_d    = aluop_q;
        alusrc_d   = alusrc_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        branch_d   = branch_q;
        rs1data_d  = rs1data_q;
        rs2data_d  = rs2data_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        funct_d    = funct_q;
        rs1addr_d  = rs1addr_q;
        rs2addr_d  = rs2addr_q;
        rdaddr_d   = rdaddr_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        if (Stall_i) begin
            // hold everything
        end else if (w_bubble) begin
            aluop_d    = 2'b00;
            alusrc_d   = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            branch_d   = 1'b0;
            rs1data_d  = '0;
            rs2data_d  = '0;
            imm_d      = '0;
            pc_d       = '0;
            funct_d    = '0;
            rs1addr_d  = '0;
            rs2addr_d  = '0;
            rdaddr_d   = '0;
            valid_d    = 1'b0;
            // Counter saturates so long runs never appear to have few bubbles
            cnt_d      = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end else begin
            aluop_d    = ALUOp_i;
            alusrc_d   = ALUSrc_i;
            regwrite_d = RegWrite_i;
            memtoreg_d = MemtoReg_i;
            memread_d  = MemRead_i;
            memwrite_d = MemWrite_i;
            branch_d   = Branch_i;
            rs1data_d  = RS1data_i;
            rs2data_d  = RS2data_i;
            imm_d      = Imm_i;
            pc_d       = PC_i;
            funct_d    = funct_i;
            rs1addr_d  = RS1addr_i;
            rs2addr_d  = RS2addr_i;
            rdaddr_d   = RDaddr_i;
            // An all-zero control word is the decoder's own bubble
            valid_d    = RegWrite_i | MemWrite_i | Branch_i | MemRead_i | (|ALUOp_i);
        end
    end

    // State register with synchronous reset taking priority over all else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aluop_q    <= 2'b00;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            rs1data_q  <= '0;
            rs2data_q  <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            funct_q    <= '0;
            rs1addr_q  <= '0;
            rs2addr_q  <= '0;
            rdaddr_q   <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            aluop_q    <= aluop_d;
            alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            branch_q   <= branch_d;
            rs1data_q  <= rs1data_d;
            rs2data_q  <= rs2data_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            funct_q    <= funct_d;
            rs1addr_q  <= rs1addr_d;
            rs2addr_q  <= rs2addr_d;
            rdaddr_q   <= rdaddr_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ALUOp_o     = aluop_q;
    assign ALUSrc_o    = alusrc_q;
    assign RegWrite_o  = regwrite_q;
    assign MemtoReg_o  = memtoreg_q;
    assign MemRead_o   = memread_q;
    assign MemWrite_o  = memwrite_q;
    assign Branch_o    = branch_q;
    assign RS1data_o   = rs1data_q;
    assign RS2data_o   = rs2data_q;
    assign Imm_o       = imm_q;
    assign PC_o        = pc_q;
    assign funct_o     = funct_q;
    assign RS1addr_o   = rs1addr_q;
    assign RS2addr_o   = rs2addr_q;
    assign RDaddr_o    = rdaddr_q;
    assign Valid_o     = valid_q;
    assign BubbleCnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_reg
// Description : Self-checking bench for id_ex_stage_reg: directed vector
//               table, randomized run against a reference model, and
//               counter-saturation sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        rst, stall, flush;
        logic [1:0]  aluop;
        logic        alusrc, regwrite, memtoreg, memread, memwrite, branch;
        logic [31:0] rs1d, rs2d, imm, pc;
        logic [9:0]  funct;
        logic [4:0]  rs1a, rs2a, rda;
    } in_t;

    typedef struct packed {
        logic [1:0]  aluop;
        logic        alusrc, regwrite, memtoreg, memread, memwrite, branch;
        logic [31:0] rs1d, rs2d, imm, pc;
        logic [9:0]  funct;
        logic [4:0]  rs1a, rs2a, rda;
        logic        valid;
        logic [15:0] cnt;
    } out_t;

    typedef struct {
        in_t         in;
        logic        e_noop, e_pcw, e_valid;
        logic [15:0] e_cnt;
        logic [1:0]  e_aluop;
        logic [31:0] e_rs1d;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t  drv;
    out_t dout;
    out_t m;
    logic noop, pcw, ifidw;
    int   checks = 0;
    int   failures = 0;

    id_ex_stage_reg #(.CNT_W(16), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(drv.rst), .Stall_i(drv.stall), .Flush_i(drv.flush),
        .ALUOp_i(drv.aluop), .ALUSrc_i(drv.alusrc), .RegWrite_i(drv.regwrite),
        .MemtoReg_i(drv.memtoreg), .MemRead_i(drv.memread), .MemWrite_i(drv.memwrite),
        .Branch_i(drv.branch), .RS1data_i(drv.rs1d), .RS2data_i(drv.rs2d),
        .Imm_i(drv.imm), .PC_i(drv.pc), .funct_i(drv.funct),
        .RS1addr_i(drv.rs1a), .RS2addr_i(drv.rs2a), .RDaddr_i(drv.rda),
        .ALUOp_o(dout.aluop), .ALUSrc_o(dout.alusrc), .RegWrite_o(dout.regwrite),
        .MemtoReg_o(dout.memtoreg), .MemRead_o(dout.memread), .MemWrite_o(dout.memwrite),
        .Branch_o(dout.branch), .RS1data_o(dout.rs1d), .RS2data_o(dout.rs2d),
        .Imm_o(dout.imm), .PC_o(dout.pc), .funct_o(dout.funct),
        .RS1addr_o(dout.rs1a), .RS2addr_o(dout.rs2a), .RDaddr_o(dout.rda),
        .Valid_o(dout.valid), .NoOp_o(noop), .PCWrite_o(pcw), .IFIDWrite_o(ifidw),
        .BubbleCnt_o(dout.cnt)
    );

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference rules: a load in EX blocks a reader of its (non-x0) destination
    function automatic logic hazard(out_t s, in_t i);
        return s.memread && s.valid && (s.rda != 0) && (s.rda == i.rs1a || s.rda == i.rs2a);
    endfunction

    function automatic out_t model_next(out_t s, in_t i);
        out_t n;
        int   c;
        if (i.rst) return '0;
        if (i.stall) return s;
        if (i.flush || hazard(s, i)) begin
            c = int'(s.cnt) + 1;
            if (c > 65535) c = 65535;
            n = '0;
            n.cnt = 16'(c);
            return n;
        end
        n.aluop = i.aluop; n.alusrc = i.alusrc; n.regwrite = i.regwrite;
        n.memtoreg = i.memtoreg; n.memread = i.memread; n.memwrite = i.memwrite;
        n.branch = i.branch; n.rs1d = i.rs1d; n.rs2d = i.rs2d; n.imm = i.imm;
        n.pc = i.pc; n.funct = i.funct; n.rs1a = i.rs1a; n.rs2a = i.rs2a; n.rda = i.rda;
        n.valid = (i.regwrite || i.memwrite || i.branch || i.memread || i.aluop != 0);
        n.cnt = s.cnt;
        return n;
    endfunction

    function automatic in_t mk(bit rst, bit stall, bit flush, logic [1:0] aluop,
                               bit regwrite, bit memread, logic [31:0] rs1d,
                               logic [4:0] rs1a, logic [4:0] rs2a, logic [4:0] rda);
        in_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.aluop = aluop;
        v.alusrc = memread; v.regwrite = regwrite; v.memtoreg = memread;
        v.memread = memread; v.memwrite = 1'b0; v.branch = 1'b0;
        v.rs1d = rs1d; v.rs2d = rs1d ^ 32'h5A5A_5A5A; v.imm = {27'd0, rda};
        v.pc = rs1d << 2; v.funct = {rs1a, rs2a};
        v.rs1a = rs1a; v.rs2a = rs2a; v.rda = rda;
        return v;
    endfunction

    function automatic in_t rnd_in();
        in_t v;
        v.rst = ($urandom_range(0, 49) == 0);
        v.stall = ($urandom_range(0, 7) == 0);
        v.flush = ($urandom_range(0, 9) == 0);
        v.aluop = 2'($urandom_range(0, 3));
        v.alusrc = 1'($urandom); v.regwrite = 1'($urandom); v.memtoreg = 1'($urandom);
        v.memread = ($urandom_range(0, 2) == 0);
        v.memwrite = ($urandom_range(0, 5) == 0);
        v.branch = ($urandom_range(0, 5) == 0);
        v.rs1d = $urandom; v.rs2d = $urandom; v.imm = $urandom; v.pc = $urandom;
        v.funct = 10'($urandom);
        v.rs1a = 5'($urandom_range(0, 7)); v.rs2a = 5'($urandom_range(0, 7));
        v.rda = 5'($urandom_range(0, 7));
        return v;
    endfunction

    // One cycle: drive, check combinational hazard outputs, clock, check state
    task automatic step(input in_t v, output logic noop_s, output logic pcw_s);
        out_t nxt;
        logic e_noop, e_pcw;
        @(negedge clk);
        drv = v;
        #1;
        e_noop = !v.rst && hazard(m, v) && !v.stall;
        e_pcw  = v.rst ? 1'b1 : !(hazard(m, v) || v.stall);
        chk("NoOp_o", 192'(noop), 192'(e_noop));
        chk("PCWrite_o", 192'(pcw), 192'(e_pcw));
        chk("IFIDWrite_o", 192'(ifidw), 192'(e_pcw));
        noop_s = noop;
        pcw_s = pcw;
        nxt = model_next(m, v);
        @(posedge clk);
        #1;
        m = nxt;
        chk("outputs", 192'(dout), 192'(m));
    endtask

    vec_t vt[$];
    logic ns, ps;

    initial begin
        m = '0;
        drv = '0;
        // Reset, add, load-use with stall/bubble, x0 case, stall priority,
        // flush+hazard, mid-stall reset, decoder bubble, plain flush
        vt.push_back('{mk(1,0,1,2'b11,1,1,32'hDEAD,5,5,5), 0,1,0,16'd0,2'b00,32'h0});
        vt.push_back('{mk(1,1,0,2'b10,1,0,32'hBEEF,1,2,3), 0,1,0,16'd0,2'b00,32'h0});
        vt.push_back('{mk(0,0,0,2'b10,1,0,32'h11,1,2,3),   0,1,1,16'd0,2'b10,32'h11});
        vt.push_back('{mk(0,0,0,2'b00,1,1,32'h100,1,0,5),  0,1,1,16'd0,2'b00,32'h100});
        vt.push_back('{mk(0,0,0,2'b10,1,0,32'h44,4,5,6),   1,0,0,16'd1,2'b00,32'h0});
        vt.push_back('{mk(0,0,0,2'b10,1,0,32'h44,4,5,6),   0,1,1,16'd1,2'b10,32'h44});
        vt.push_back('{mk(0,0,0,2'b00,1,1,32'h200,1,0,0),  0,1,1,16'd1,2'b00,32'h200});
        vt.push_back('{mk(0,0,0,2'b10,1,0,32'h77,0,0,7),   0,1,1,16'd1,2'b10,32'h77});
        vt.push_back('{mk(0,0,0,2'b00,1,1,32'h300,1,0,5),  0,1,1,16'd1,2'b00,32'h300});
        vt.push_back('{mk(0,1,1,2'b10,1,0,32'h99,4,5,6),   0,0,1,16'd1,2'b00,32'h300});
        vt.push_back('{mk(0,1,1,2'b10,1,0,32'h99,4,5,6),   0,0,1,16'd1,2'b00,32'h300});
        vt.push_back('{mk(0,1,1,2'b10,1,0,32'h99,4,5,6),   0,0,1,16'd1,2'b00,32'h300});
        vt.push_back('{mk(0,0,1,2'b10,1,0,32'h99,4,5,6),   1,0,0,16'd2,2'b00,32'h0});
        vt.push_back('{mk(0,0,0,2'b10,1,0,32'h55,1,2,3),   0,1,1,16'd2,2'b10,32'h55});
        vt.push_back('{mk(1,1,0,2'b10,1,0,32'h66,1,2,3),   0,1,0,16'd0,2'b00,32'h0});
        vt.push_back('{mk(0,0,0,2'b00,0,0,32'hAB,1,2,3),   0,1,0,16'd0,2'b00,32'hAB});
        vt.push_back('{mk(0,0,1,2'b10,1,0,32'hCD,1,2,3),   0,1,0,16'd1,2'b00,32'h0});

        for (int k = 0; k < vt.size(); k++) begin
            step(vt[k].in, ns, ps);
            chk($sformatf("v%0d noop", k), 192'(ns), 192'(vt[k].e_noop));
            chk($sformatf("v%0d pcwrite", k), 192'(ps), 192'(vt[k].e_pcw));
            chk($sformatf("v%0d valid", k), 192'(dout.valid), 192'(vt[k].e_valid));
            chk($sformatf("v%0d bubblecnt", k), 192'(dout.cnt), 192'(vt[k].e_cnt));
            chk($sformatf("v%0d aluop", k), 192'(dout.aluop), 192'(vt[k].e_aluop));
            chk($sformatf("v%0d rs1data", k), 192'(dout.rs1d), 192'(vt[k].e_rs1d));
        end

        for (int k = 0; k < 400; k++) begin
            step(rnd_in(), ns, ps);
        end

        // Counter saturation: reset, run flushes up to one below the max
        step(mk(1,0,0,2'b00,0,0,32'h0,0,0,0), ns, ps);
        drv = mk(0,0,1,2'b10,1,0,32'h1234,1,2,3);
        repeat (65534) @(posedge clk);
        #1;
        m = '0;
        m.cnt = 16'hFFFE;
        chk("cnt preload", 192'(dout.cnt), 192'(16'hFFFE));
        step(mk(0,0,1,2'b10,1,0,32'h1,1,2,3), ns, ps);
        chk("cnt reach max", 192'(dout.cnt), 192'(16'hFFFF));
        step(mk(0,0,1,2'b10,1,0,32'h2,1,2,3), ns, ps);
        chk("cnt saturate", 192'(dout.cnt), 192'(16'hFFFF));
        step(mk(0,0,0,2'b10,1,0,32'h3,1,2,3), ns, ps);
        chk("cnt hold on load", 192'(dout.cnt), 192'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
